// File: rtl/rggen_bus_access_sequencer_if.sv
// Bundle of host-request, host-response and register-broadcast signals
// around rggen_bus_access_sequencer. The sequencer uses the slave modport;
// the host bridge plus register block side uses the master modport.
interface rggen_bus_access_sequencer_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int REGISTERS     = 1
);
  // host request
  logic                            i_bus_valid;
  logic [1:0]                      i_bus_access;
  logic [ADDRESS_WIDTH-1:0]        i_bus_address;
  logic [BUS_WIDTH-1:0]            i_bus_write_data;
  logic [BUS_WIDTH/8-1:0]          i_bus_strobe;
  // host response
  logic                            o_bus_ready;
  logic [1:0]                      o_bus_status;
  logic [BUS_WIDTH-1:0]            o_bus_read_data;
  // broadcast request to the registers
  logic                            o_reg_valid;
  logic [1:0]                      o_reg_access;
  logic [ADDRESS_WIDTH-1:0]        o_reg_address;
  logic [BUS_WIDTH-1:0]            o_reg_write_data;
  logic [BUS_WIDTH/8-1:0]          o_reg_strobe;
  // per-register responses
  logic [REGISTERS-1:0]            i_reg_active;
  logic [REGISTERS-1:0]            i_reg_ready;
  logic [2*REGISTERS-1:0]          i_reg_status;
  logic [BUS_WIDTH*REGISTERS-1:0]  i_reg_read_data;

  modport slave (
    input  i_bus_valid, i_bus_access, i_bus_address, i_bus_write_data, i_bus_strobe,
    output o_bus_ready, o_bus_status, o_bus_read_data,
    output o_reg_valid, o_reg_access, o_reg_address, o_reg_write_data, o_reg_strobe,
    input  i_reg_active, i_reg_ready, i_reg_status, i_reg_read_data
  );

  modport master (
    output i_bus_valid, i_bus_access, i_bus_address, i_bus_write_data, i_bus_strobe,
    input  o_bus_ready, o_bus_status, o_bus_read_data,
    input  o_reg_valid, o_reg_access, o_reg_address, o_reg_write_data, o_reg_strobe,
    output i_reg_active, i_reg_ready, i_reg_status, i_reg_read_data
  );
endinterface

// File: rtl/rggen_bus_access_sequencer.sv
// Registers one host request, broadcasts it to the registers of a block,
// and returns exactly one response per request (hit, decode error, or
// optional timeout).
// Optional feature macro: RGGEN_ACCESS_TIMEOUT_EN -- when defined, a BUSY
// access that no register completes within TIMEOUT_CYCLES ends in
// SLAVE_ERROR; when undefined, BUSY waits indefinitely.
module rggen_bus_access_sequencer #(
  parameter int                       ADDRESS_WIDTH  = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS   = '0,
  parameter int                       BYTE_SIZE      = 256,
  parameter int                       BUS_WIDTH      = 32,
  parameter int                       REGISTERS      = 1,
  parameter bit                       ERROR_STATUS   = 1'b1,
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input logic                         i_clk,
  input logic                         i_rst_n,
  rggen_bus_access_sequencer_if.slave bus_if
);
  localparam logic [1:0] RGGEN_OKAY            = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR     = 2'b10;
  localparam int         RGGEN_ACCESS_DATA_BIT = 1;
  localparam int         STROBE_WIDTH          = BUS_WIDTH / 8;
  // one extra bit so a window ending exactly at 2**ADDRESS_WIDTH does not wrap
  localparam int                     WIN_WIDTH = ADDRESS_WIDTH + 1;
  localparam logic [WIN_WIDTH-1:0]   WIN_LO    = {1'b0, BASE_ADDRESS};
  localparam logic [WIN_WIDTH-1:0]   WIN_HI    = WIN_LO + WIN_WIDTH'(BYTE_SIZE);
  localparam logic [1:0]             UNMAPPED_STATUS = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               access_q, access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
  logic [STROBE_WIDTH-1:0]  strobe_q, strobe_d;
  logic [1:0]               status_q, status_d;
  logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;

  logic                     in_window;
  logic [REGISTERS-1:0]     hit;
  logic [1:0]               hit_status;
  logic [BUS_WIDTH-1:0]     hit_data;
  logic                     is_write;

  assign in_window = ({1'b0, bus_if.i_bus_address} >= WIN_LO) &&
                     ({1'b0, bus_if.i_bus_address} <  WIN_HI);
  assign hit       = bus_if.i_reg_active & bus_if.i_reg_ready;
  assign is_write  = access_q[RGGEN_ACCESS_DATA_BIT];

  // AND-OR mux over the completing registers; multiple hits simply OR together
  always_comb begin
    hit_status = '0;
    hit_data   = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      hit_status = hit_status | ({2{hit[i]}} & bus_if.i_reg_status[2*i+:2]);
      hit_data   = hit_data   | ({BUS_WIDTH{hit[i]}} & bus_if.i_reg_read_data[BUS_WIDTH*i+:BUS_WIDTH]);
    end
  end

`ifdef RGGEN_ACCESS_TIMEOUT_EN
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   timed_out;
  assign timed_out = (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES));

  // BUSY-cycle counter, cleared whenever the FSM is outside BUSY
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  // next-state, request latch and response capture
  always_comb begin
    state_d      = state_q;
    access_d     = access_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    status_d     = status_q;
    read_data_d  = read_data_q;
`ifdef RGGEN_ACCESS_TIMEOUT_EN
    timer_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus_if.i_bus_valid) begin
          access_d     = bus_if.i_bus_access;
          address_d    = bus_if.i_bus_address;
          write_data_d = bus_if.i_bus_write_data;
          strobe_d     = bus_if.i_bus_strobe;
          if (in_window) begin
            state_d = BUSY;
          end else begin
            // outside the block: answer directly without bothering the registers
            state_d     = RESPOND;
            status_d    = UNMAPPED_STATUS;
            read_data_d = '0;
          end
        end
      end
      BUSY: begin
`ifdef RGGEN_ACCESS_TIMEOUT_EN
        timer_d = timer_q + 1'b1;
`endif
        if (|hit) begin
          state_d     = RESPOND;
          status_d    = hit_status;
          read_data_d = is_write ? '0 : hit_data;
        end else if (bus_if.i_reg_active == '0) begin
          state_d     = RESPOND;
          status_d    = UNMAPPED_STATUS;
          read_data_d = '0;
        end
`ifdef RGGEN_ACCESS_TIMEOUT_EN
        else if (timed_out) begin
          state_d     = RESPOND;
          status_d    = RGGEN_SLAVE_ERROR;
          read_data_d = '0;
        end
`endif
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      access_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      status_q     <= RGGEN_OKAY;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      access_q     <= access_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
      status_q     <= status_d;
      read_data_q  <= read_data_d;
    end
  end

  assign bus_if.o_bus_ready      = (state_q == RESPOND);
  assign bus_if.o_bus_status     = status_q;
  assign bus_if.o_bus_read_data  = read_data_q;
  assign bus_if.o_reg_valid      = (state_q == BUSY);
  assign bus_if.o_reg_access     = access_q;
  assign bus_if.o_reg_address    = address_q;
  assign bus_if.o_reg_write_data = write_data_q;
  assign bus_if.o_reg_strobe     = strobe_q;
endmodule

// File: tb/tb_rggen_bus_access_sequencer.sv
// Scoreboard bench for rggen_bus_access_sequencer. Three instances:
//   A: 8-bit address, 2 registers, ERROR_STATUS=1, TIMEOUT_CYCLES=4
//   B: 8-bit address, 2 registers, ERROR_STATUS=0
//   C: 9-bit address, 1 register, 256-byte window at 0
module tb_rggen_bus_access_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  rggen_bus_access_sequencer_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2)) if_a ();
  rggen_bus_access_sequencer_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2)) if_b ();
  rggen_bus_access_sequencer_if #(.ADDRESS_WIDTH(9), .BUS_WIDTH(32), .REGISTERS(1)) if_c ();

  rggen_bus_access_sequencer #(
    .ADDRESS_WIDTH(8), .BASE_ADDRESS(8'h00), .BYTE_SIZE(256), .BUS_WIDTH(32),
    .REGISTERS(2), .ERROR_STATUS(1'b1), .TIMEOUT_CYCLES(4)
  ) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus_if(if_a));

  rggen_bus_access_sequencer #(
    .ADDRESS_WIDTH(8), .BASE_ADDRESS(8'h00), .BYTE_SIZE(256), .BUS_WIDTH(32),
    .REGISTERS(2), .ERROR_STATUS(1'b0), .TIMEOUT_CYCLES(255)
  ) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus_if(if_b));

  rggen_bus_access_sequencer #(
    .ADDRESS_WIDTH(9), .BASE_ADDRESS(9'h000), .BYTE_SIZE(256), .BUS_WIDTH(32),
    .REGISTERS(1), .ERROR_STATUS(1'b1), .TIMEOUT_CYCLES(255)
  ) dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus_if(if_c));

  // shared host stimulus; each instance has its own valid
  logic [2:0]  tb_valid;
  logic [1:0]  tb_access;
  logic [8:0]  tb_addr;
  logic [31:0] tb_wdata;
  logic [3:0]  tb_strobe;

  assign if_a.i_bus_valid = tb_valid[0];
  assign if_b.i_bus_valid = tb_valid[1];
  assign if_c.i_bus_valid = tb_valid[2];
  assign if_a.i_bus_access = tb_access;
  assign if_b.i_bus_access = tb_access;
  assign if_c.i_bus_access = tb_access;
  assign if_a.i_bus_address = tb_addr[7:0];
  assign if_b.i_bus_address = tb_addr[7:0];
  assign if_c.i_bus_address = tb_addr;
  assign if_a.i_bus_write_data = tb_wdata;
  assign if_b.i_bus_write_data = tb_wdata;
  assign if_c.i_bus_write_data = tb_wdata;
  assign if_a.i_bus_strobe = tb_strobe;
  assign if_b.i_bus_strobe = tb_strobe;
  assign if_c.i_bus_strobe = tb_strobe;

  // register-side models: reg0 at 0x00, reg1 at 0x04
  int         ready_delay;
  int         a_busy_cnt = 0;
  logic [1:0] reg0_status;
  logic [1:0] a_active, b_active;
  logic       c_active;

  always @(posedge clk) a_busy_cnt <= if_a.o_reg_valid ? a_busy_cnt + 1 : 0;

  always_comb begin
    a_active = 2'b00;
    if (if_a.o_reg_valid && if_a.o_reg_address == 8'h00) a_active[0] = 1'b1;
    if (if_a.o_reg_valid && if_a.o_reg_address == 8'h04) a_active[1] = 1'b1;
    b_active = 2'b00;
    if (if_b.o_reg_valid && if_b.o_reg_address == 8'h00) b_active[0] = 1'b1;
    if (if_b.o_reg_valid && if_b.o_reg_address == 8'h04) b_active[1] = 1'b1;
    c_active = if_c.o_reg_valid && (if_c.o_reg_address == 9'h000);
  end

  assign if_a.i_reg_active    = a_active;
  assign if_a.i_reg_ready     = a_active & {2{a_busy_cnt >= ready_delay}};
  assign if_a.i_reg_status    = {2'b00, reg0_status};
  assign if_a.i_reg_read_data = {32'hA5A5_0001, 32'h1111_0000};
  assign if_b.i_reg_active    = b_active;
  assign if_b.i_reg_ready     = b_active;
  assign if_b.i_reg_status    = 4'b0000;
  assign if_b.i_reg_read_data = {32'h3333_0004, 32'h3333_0000};
  assign if_c.i_reg_active    = c_active;
  assign if_c.i_reg_ready     = c_active;
  assign if_c.i_reg_status    = 2'b00;
  assign if_c.i_reg_read_data = 32'h2222_0000;

  // per-instance views for the monitor
  logic [2:0]  rdy, regv;
  logic [1:0]  stat [3];
  logic [31:0] rdat [3];
  assign rdy  = {if_c.o_bus_ready, if_b.o_bus_ready, if_a.o_bus_ready};
  assign regv = {if_c.o_reg_valid, if_b.o_reg_valid, if_a.o_reg_valid};
  assign stat[0] = if_a.o_bus_status;
  assign stat[1] = if_b.o_bus_status;
  assign stat[2] = if_c.o_bus_status;
  assign rdat[0] = if_a.o_bus_read_data;
  assign rdat[1] = if_b.o_bus_read_data;
  assign rdat[2] = if_c.o_bus_read_data;

  typedef struct {
    int          id;
    logic [1:0]  st;
    logic [31:0] data;
    int          cyc;
    int          busy;
  } exp_t;
  exp_t exp_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_resp(input int id, input logic [1:0] st, input logic [31:0] d, input int vc);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_response: dut %0d status %0b data 0x%0h with empty scoreboard", id, st, d);
    end else begin
      e = exp_q.pop_front();
      cmp("resp_dut", 32'(id), 32'(e.id));
      cmp("resp_status", 32'(st), 32'(e.st));
      cmp("resp_data", d, e.data);
      cmp("resp_cycle", 32'(cyc), 32'(e.cyc));
      cmp("reg_valid_cycles", 32'(vc), 32'(e.busy));
      $display("dut %0d resp: status=%0b data=0x%08h cycle=%0d reg_valid_cycles=%0d", id, st, d, cyc, vc);
    end
  endtask

  // monitor: counts broadcast cycles, scores every response, checks latched request
  int vcnt [3] = '{0, 0, 0};
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (regv[i]) begin
          vcnt[i]++;
        end else begin
          if (rdy[i]) check_resp(i, stat[i], rdat[i], vcnt[i]);
          vcnt[i] = 0;
        end
      end
      if (if_a.o_reg_valid) begin
        cmp("reg_access", 32'(if_a.o_reg_access), 32'(tb_access));
        cmp("reg_address", 32'(if_a.o_reg_address), 32'(tb_addr[7:0]));
        cmp("reg_write_data", if_a.o_reg_write_data, tb_wdata);
        cmp("reg_strobe", 32'(if_a.o_reg_strobe), 32'(tb_strobe));
      end
    end
  end

  // issue one request; expected response is queued before the DUT can answer
  task automatic issue(input int id, input logic [1:0] acc, input logic [8:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb,
                       input logic [1:0] est, input logic [31:0] edata, input int ebusy);
    exp_t e;
    bit   got;
    @(negedge clk);
    tb_access = acc;
    tb_addr   = addr;
    tb_wdata  = wd;
    tb_strobe = strb;
    tb_valid[id] = 1'b1;
    e.id = id; e.st = est; e.data = edata; e.cyc = cyc + 1 + ebusy; e.busy = ebusy;
    exp_q.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (rdy[id]) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: dut %0d addr 0x%0h no o_bus_ready within 40 cycles", id, addr);
      void'(exp_q.pop_front());
    end
    tb_valid[id] = 1'b0;
  endtask

  task automatic check_reset_a();
    cmp("rst_bus_ready", 32'(if_a.o_bus_ready), 32'h0);
    cmp("rst_bus_status", 32'(if_a.o_bus_status), 32'h0);
    cmp("rst_bus_read_data", if_a.o_bus_read_data, 32'h0);
    cmp("rst_reg_valid", 32'(if_a.o_reg_valid), 32'h0);
    cmp("rst_reg_access", 32'(if_a.o_reg_access), 32'h0);
    cmp("rst_reg_address", 32'(if_a.o_reg_address), 32'h0);
    cmp("rst_reg_write_data", if_a.o_reg_write_data, 32'h0);
    cmp("rst_reg_strobe", 32'(if_a.o_reg_strobe), 32'h0);
  endtask

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b10;

  initial begin
    rst_n = 1'b0;
    tb_valid = 3'b000; tb_access = RD; tb_addr = '0; tb_wdata = '0; tb_strobe = '0;
    ready_delay = 0; reg0_status = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_a();
    cmp("rst_c_reg_valid", 32'(if_c.o_reg_valid), 32'h0);
    rst_n = 1'b1;

    // instance A: hits, write, decode error
    issue(0, RD, 9'h004, 32'h0, 4'hF, 2'b00, 32'hA5A5_0001, 1);
    reg0_status = 2'b10;
    issue(0, RD, 9'h000, 32'h0, 4'hF, 2'b10, 32'h1111_0000, 1);
    reg0_status = 2'b00;
    ready_delay = 2;
    issue(0, WR, 9'h004, 32'h1234_5678, 4'b0011, 2'b00, 32'h0, 3);
    ready_delay = 0;
    issue(0, RD, 9'h00C, 32'h0, 4'hF, 2'b10, 32'h0, 1);

`ifdef RGGEN_ACCESS_TIMEOUT_EN
    ready_delay = 255;
    issue(0, RD, 9'h004, 32'h0, 4'hF, 2'b10, 32'h0, 5);
    ready_delay = 4;
    issue(0, RD, 9'h004, 32'h0, 4'hF, 2'b00, 32'hA5A5_0001, 5);
`else
    ready_delay = 7;
    issue(0, RD, 9'h004, 32'h0, 4'hF, 2'b00, 32'hA5A5_0001, 8);
`endif
    ready_delay = 0;
    issue(0, WR, 9'h00C, 32'hCAFE_0000, 4'hF, 2'b10, 32'h0, 1);

    // reset while BUSY drops the access
    @(negedge clk);
    tb_access = WR; tb_addr = 9'h004; tb_wdata = 32'hDEAD_BEEF; tb_strobe = 4'hF;
    ready_delay = 255;
    tb_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    cmp("busy_before_reset", 32'(if_a.o_reg_valid), 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tb_valid[0] = 1'b0;
    @(negedge clk);
    check_reset_a();
    ready_delay = 0;
    issue(0, RD, 9'h004, 32'h0, 4'hF, 2'b00, 32'hA5A5_0001, 1);

    // instance B: unmapped access answers OKAY
    issue(1, RD, 9'h00C, 32'h0, 4'hF, 2'b00, 32'h0, 1);
    issue(1, RD, 9'h004, 32'h0, 4'hF, 2'b00, 32'h3333_0004, 1);

    // instance C: 9-bit addresses around the window edge
    issue(2, RD, 9'h100, 32'h0, 4'hF, 2'b10, 32'h0, 0);
    issue(2, RD, 9'h000, 32'h0, 4'hF, 2'b00, 32'h2222_0000, 1);
    issue(2, RD, 9'h0FF, 32'h0, 4'hF, 2'b10, 32'h0, 1);
    issue(2, WR, 9'h1FF, 32'h5555_AAAA, 4'hF, 2'b10, 32'h0, 0);

    repeat (3) @(negedge clk);
    cmp("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
